p_hit_dispatch: RTL and testbench
=================================

// Module: p_hit_dispatch
// PURPOSE
//  Sequencer in front of the p_hit plane-intersection datapath. Pops one ray/triangle job from an upstream FIFO
//  and fans it out to p_hit's four independent input FIFOs, writing each lane as soon as it has room.
//  Tracks jobs in flight, caps them at MAX_INFLIGHT and re-attaches each job ID to the hit point p_hit returns.
// PARAMETERS
//  D_BITS       32  fixed-point word width (Q16.16 by default)
//  Q_BITS       16  fractional bits (pass-through only; no arithmetic here)
//  ID_BITS       8  job tag width
//  MAX_INFLIGHT 16  max jobs accepted but not yet returned (power of 2, >=2)
// PORTS
//  clock           in   1            system clock
//  reset           in   1            asynchronous, active-high
//  job_normal      in   D_BITS x3    triangle normal [x,y,z]
//  job_v0          in   D_BITS x3    triangle vertex 0
//  job_origin      in   D_BITS x3    ray origin
//  job_dir         in   D_BITS x3    ray direction
//  job_id          in   ID_BITS      job tag
//  job_empty       in   1            upstream FIFO empty (first-word-fall-through)
//  job_rd_en       out  1            pop upstream FIFO
//  ph_tri_normal_1/_2, ph_v0, ph_origin_1/_2, ph_dir_1/_2   out D_BITS x3   p_hit operands
//  ph_in_wr_en     out  4            per-lane write to p_hit FIFOs
//  ph_in_full      in   4            per-lane full from p_hit
//  ph_out          in   D_BITS x3    hit point from p_hit
//  ph_out_empty    in   1            p_hit result FIFO empty
//  ph_out_rd_en    out  1            pop p_hit result
//  res_p           out  D_BITS x3    hit point to downstream
//  res_id          out  ID_BITS      matching job tag
//  res_wr_en       out  1            push to downstream FIFO
//  res_full        in   1            downstream FIFO full
//  err_underflow   out  1            sticky: result popped with no tag queued
// BEHAVIOUR
//  - Reset: state=IDLE, lane_done=4'b0, inflight=0, tag queue empty, operand regs 0, err_underflow=0.
//    All strobes (job_rd_en, ph_in_wr_en, ph_out_rd_en, res_wr_en) are combinational and 0 while reset is high.
//  - Reset mid-issue drops the partly written job; p_hit shares the same reset, so lanes never desynchronise.
//  - IDLE: accept when !job_empty && inflight<MAX_INFLIGHT. Then job_rd_en=1 for one cycle, all job_* latched
//    into operand regs, job_id pushed to tag queue, lane_done cleared -> ISSUE.
//  - Operand regs drive all ph_* operand outputs; both normal ports carry job_normal, origin_1/_2 carry
//    job_origin, and dir_1/_2 carry job_dir.
//  - ISSUE: ph_in_wr_en[i] = !lane_done[i] && !ph_in_full[i]; lane_done |= ph_in_wr_en.
//    When (lane_done|ph_in_wr_en)==4'hF -> IDLE. Operand regs hold steady throughout ISSUE.
//    Minimum of 2 cycles per job; no new pop happens in the ISSUE cycle.
//  - Drain (concurrent with FSM): ph_out_rd_en = res_wr_en = !ph_out_empty && !res_full.
//    res_p=ph_out; res_id=tag queue head, popped on res_wr_en.
//  - inflight +1 on accept, -1 on res_wr_en; both in one cycle -> unchanged. Never wraps.
//  - Tag queue empty at res_wr_en: res_id=0, err_underflow set until reset, inflight held at 0.
// CONFIGURATION
//  `P_HIT_DISPATCH_STATS_EN defined: adds outputs stat_jobs, stat_results, stat_stall (32b each, saturating at all-ones).
//    stat_jobs counts accepts; stat_results counts res_wr_en; stat_stall counts ISSUE cycles with any
//    undone lane full. All three reset to 0.
//  Macro undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  p_hit_pkg: phd_state_e {IDLE, ISSUE}, NUM_LANES=4, lane index constants (LANE_P1_A, LANE_P1_B, LANE_DIR2, LANE_ORG2).
//  Sub-module p_hit_tag_fifo: sync FIFO, ID_BITS wide, MAX_INFLIGHT deep, first-word-fall-through.
// TESTING
//  1. Single job: dir=(0x10000,0,0), id=0x2A, no backpressure -> ph_in_wr_en=4'hF in 1 cycle;
//     res_id=0x2A with ph_out passed through unchanged.
//  2. ph_in_full=4'b0101 for 3 cycles -> lanes 0,2 written after release, lanes 1,3 at once;
//     each lane written exactly once; stat_stall=3 when the macro is defined.
//  3. 17 jobs, ph_out_empty=1 -> exactly 16 job_rd_en, 17th held until one result drains; inflight<=16.
//  4. res_full=1 while ph_out_empty=0 -> ph_out_rd_en=0, res_wr_en=0; after release, ids leave in accept order.
//  5. Result pushed with no job issued -> err_underflow=1 and stays 1; res_id=0.
//  6. Reset asserted mid-ISSUE with lane_done=4'b0011 -> all strobes 0 immediately; IDLE, inflight=0 after release.

Source files
------------

// File: rtl/p_hit_pkg.sv
// Shared types and constants for the p_hit dispatch sequencer.
package p_hit_pkg;

  // Dispatcher FSM: wait for a job, or fan the latched job out to the lanes
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } phd_state_e;

  // p_hit exposes four independent operand FIFOs
  localparam int unsigned NUM_LANES = 4;

  localparam int unsigned LANE_P1_A = 0;
  localparam int unsigned LANE_P1_B = 1;
  localparam int unsigned LANE_DIR2 = 2;
  localparam int unsigned LANE_ORG2 = 3;

  // Width of the optional statistics counters
  localparam int unsigned STAT_BITS = 32;

endpackage

// File: rtl/p_hit_tag_fifo.sv
// Job-tag queue: synchronous first-word-fall-through FIFO.
// The head word is valid whenever empty is low; overflowing pushes and
// underflowing pops are ignored.
module p_hit_tag_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                do_push;
  logic                do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/p_hit_dispatch.sv
// p_hit_dispatch: pops ray/triangle jobs, fans each one out to the four p_hit
// operand lanes, caps jobs in flight and re-attaches job tags to returned hits.
// Optional statistics counters: define P_HIT_DISPATCH_STATS_EN.
module p_hit_dispatch
  import p_hit_pkg::*;
#(
  parameter int unsigned D_BITS       = 32,
  parameter int unsigned Q_BITS       = 16,
  parameter int unsigned ID_BITS      = 8,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0][D_BITS-1:0]       job_normal,
  input  logic [2:0][D_BITS-1:0]       job_v0,
  input  logic [2:0][D_BITS-1:0]       job_origin,
  input  logic [2:0][D_BITS-1:0]       job_dir,
  input  logic [ID_BITS-1:0]           job_id,
  input  logic                         job_empty,
  output logic                         job_rd_en,
  output logic [2:0][D_BITS-1:0]       ph_tri_normal_1,
  output logic [2:0][D_BITS-1:0]       ph_tri_normal_2,
  output logic [2:0][D_BITS-1:0]       ph_v0,
  output logic [2:0][D_BITS-1:0]       ph_origin_1,
  output logic [2:0][D_BITS-1:0]       ph_origin_2,
  output logic [2:0][D_BITS-1:0]       ph_dir_1,
  output logic [2:0][D_BITS-1:0]       ph_dir_2,
  output logic [NUM_LANES-1:0]         ph_in_wr_en,
  input  logic [NUM_LANES-1:0]         ph_in_full,
  input  logic [2:0][D_BITS-1:0]       ph_out,
  input  logic                         ph_out_empty,
  output logic                         ph_out_rd_en,
  output logic [2:0][D_BITS-1:0]       res_p,
  output logic [ID_BITS-1:0]           res_id,
  output logic                         res_wr_en,
  input  logic                         res_full,
  output logic                         err_underflow
`ifdef P_HIT_DISPATCH_STATS_EN
  ,
  output logic [STAT_BITS-1:0]         stat_jobs,
  output logic [STAT_BITS-1:0]         stat_results,
  output logic [STAT_BITS-1:0]         stat_stall
`endif
);

  localparam int unsigned INF_BITS = $clog2(MAX_INFLIGHT) + 1;

  // Reject configurations the tag queue and in-flight counter cannot support
  if (MAX_INFLIGHT < 2 || (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0 || Q_BITS > D_BITS) begin : g_bad_cfg
    $error("p_hit_dispatch: unsupported parameter set");
  end

  phd_state_e               state;
  phd_state_e               state_nx;
  logic [NUM_LANES-1:0]     lane_done;
  logic [NUM_LANES-1:0]     lane_done_nx;
  logic [NUM_LANES-1:0]     lane_wr;
  logic                     accept;
  logic                     room;
  logic                     drain;
  logic                     tag_pop;
  logic                     tag_empty;
  logic [ID_BITS-1:0]       tag_head;
  logic [INF_BITS-1:0]      inflight;
  logic [2:0][D_BITS-1:0]   normal_q;
  logic [2:0][D_BITS-1:0]   v0_q;
  logic [2:0][D_BITS-1:0]   origin_q;
  logic [2:0][D_BITS-1:0]   dir_q;

  assign room    = (inflight < INF_BITS'(MAX_INFLIGHT));
  assign drain   = !reset && !ph_out_empty && !res_full;
  assign tag_pop = drain && !tag_empty;

  // FSM state and lane-progress registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lane_done <= '0;
    end else begin
      state     <= state_nx;
      lane_done <= lane_done_nx;
    end
  end

  // Next state, job acceptance and per-lane write strobes
  always_comb begin
    state_nx     = state;
    lane_done_nx = lane_done;
    accept       = 1'b0;
    lane_wr      = '0;
    unique case (state)
      IDLE: begin
        if (!reset && !job_empty && room) begin
          accept       = 1'b1;
          lane_done_nx = '0;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        lane_wr      = ~lane_done & ~ph_in_full & {NUM_LANES{!reset}};
        lane_done_nx = lane_done | lane_wr;
        if (&lane_done_nx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign job_rd_en    = accept;
  assign ph_in_wr_en  = lane_wr;
  assign ph_out_rd_en = drain;
  assign res_wr_en    = drain;
  assign res_p        = ph_out;
  assign res_id       = tag_empty ? '0 : tag_head;

  // Operand capture; held steady while the lanes are being written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      normal_q <= '0;
      v0_q     <= '0;
      origin_q <= '0;
      dir_q    <= '0;
    end else if (accept) begin
      normal_q <= job_normal;
      v0_q     <= job_v0;
      origin_q <= job_origin;
      dir_q    <= job_dir;
    end
  end

  assign ph_tri_normal_1 = normal_q;
  assign ph_tri_normal_2 = normal_q;
  assign ph_v0           = v0_q;
  assign ph_origin_1     = origin_q;
  assign ph_origin_2     = origin_q;
  assign ph_dir_1        = dir_q;
  assign ph_dir_2        = dir_q;

  // In-flight count mirrors the tag queue occupancy, so it can never wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      unique case ({accept, tag_pop})
        2'b10:   inflight <= inflight + INF_BITS'(1);
        2'b01:   inflight <= inflight - INF_BITS'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag: a result left with no job tag to pair it with
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else if (drain && tag_empty) begin
      err_underflow <= 1'b1;
    end
  end

  p_hit_tag_fifo #(
    .WIDTH (ID_BITS),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (job_id),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty)
  );

`ifdef P_HIT_DISPATCH_STATS_EN
  logic stall;
  assign stall = (state == ISSUE) && |(~lane_done & ph_in_full);

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_jobs    <= '0;
      stat_results <= '0;
      stat_stall   <= '0;
    end else begin
      if (accept && stat_jobs != '1)    stat_jobs    <= stat_jobs + STAT_BITS'(1);
      if (drain && stat_results != '1)  stat_results <= stat_results + STAT_BITS'(1);
      if (stall && stat_stall != '1)    stat_stall   <= stat_stall + STAT_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_p_hit_dispatch.sv
// Self-checking bench for p_hit_dispatch (also covers P_HIT_DISPATCH_STATS_EN builds).
module tb_p_hit_dispatch;

  localparam int unsigned D_BITS       = 32;
  localparam int unsigned ID_BITS      = 8;
  localparam int unsigned MAX_INFLIGHT = 16;

  typedef logic [2:0][D_BITS-1:0] vec_t;

  logic               clock = 1'b0;
  logic               reset;
  vec_t               job_normal, job_v0, job_origin, job_dir;
  logic [ID_BITS-1:0] job_id;
  logic               job_empty;
  logic               job_rd_en;
  vec_t               ph_tri_normal_1, ph_tri_normal_2, ph_v0;
  vec_t               ph_origin_1, ph_origin_2, ph_dir_1, ph_dir_2;
  logic [3:0]         ph_in_wr_en;
  logic [3:0]         ph_in_full;
  vec_t               ph_out;
  logic               ph_out_empty;
  logic               ph_out_rd_en;
  vec_t               res_p;
  logic [ID_BITS-1:0] res_id;
  logic               res_wr_en;
  logic               res_full;
  logic               err_underflow;
`ifdef P_HIT_DISPATCH_STATS_EN
  logic [31:0]        stat_jobs, stat_results, stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  p_hit_dispatch #(
    .D_BITS(D_BITS), .Q_BITS(16), .ID_BITS(ID_BITS), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clock(clock), .reset(reset),
    .job_normal(job_normal), .job_v0(job_v0), .job_origin(job_origin), .job_dir(job_dir),
    .job_id(job_id), .job_empty(job_empty), .job_rd_en(job_rd_en),
    .ph_tri_normal_1(ph_tri_normal_1), .ph_tri_normal_2(ph_tri_normal_2), .ph_v0(ph_v0),
    .ph_origin_1(ph_origin_1), .ph_origin_2(ph_origin_2),
    .ph_dir_1(ph_dir_1), .ph_dir_2(ph_dir_2),
    .ph_in_wr_en(ph_in_wr_en), .ph_in_full(ph_in_full),
    .ph_out(ph_out), .ph_out_empty(ph_out_empty), .ph_out_rd_en(ph_out_rd_en),
    .res_p(res_p), .res_id(res_id), .res_wr_en(res_wr_en), .res_full(res_full),
    .err_underflow(err_underflow)
`ifdef P_HIT_DISPATCH_STATS_EN
    , .stat_jobs(stat_jobs), .stat_results(stat_results), .stat_stall(stat_stall)
`endif
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pending job, remaining lanes, tag queue in accept order
  logic [ID_BITS-1:0] mq[$];
  bit                 m_busy;
  logic [3:0]         m_pend;
  vec_t               m_n, m_v, m_o, m_d;
  bit                 m_err;
  int                 m_jobs, m_res, m_stall;

  // Compare process: check every output against the model, then advance the model
  always @(negedge clock) begin
    logic       e_rd;
    logic       e_dr;
    logic [3:0] e_wr;
    if (reset) begin
      mq.delete();
      m_busy = 0; m_pend = '0; m_err = 0;
      m_n = '0; m_v = '0; m_o = '0; m_d = '0;
      m_jobs = 0; m_res = 0; m_stall = 0;
    end
    e_rd = !reset && !m_busy && !job_empty && (mq.size() < MAX_INFLIGHT);
    e_wr = (!reset && m_busy) ? (m_pend & ~ph_in_full) : 4'h0;
    e_dr = !reset && !ph_out_empty && !res_full;
    check("job_rd_en", job_rd_en, e_rd);
    check("ph_in_wr_en", ph_in_wr_en, e_wr);
    check("ph_out_rd_en", ph_out_rd_en, e_dr);
    check("res_wr_en", res_wr_en, e_dr);
    if (e_dr) begin
      check("res_id", res_id, (mq.size() != 0) ? mq[0] : 8'h00);
      check("res_p", res_p, ph_out);
    end
    check("normal_1", ph_tri_normal_1, m_n);
    check("normal_2", ph_tri_normal_2, m_n);
    check("v0", ph_v0, m_v);
    check("origin_1", ph_origin_1, m_o);
    check("origin_2", ph_origin_2, m_o);
    check("dir_1", ph_dir_1, m_d);
    check("dir_2", ph_dir_2, m_d);
    check("err_underflow", err_underflow, m_err);
    check("inflight_cap", mq.size() <= MAX_INFLIGHT, 1);
`ifdef P_HIT_DISPATCH_STATS_EN
    check("stat_jobs", stat_jobs, m_jobs);
    check("stat_results", stat_results, m_res);
    check("stat_stall", stat_stall, m_stall);
`endif
    if (!reset) begin
      if (m_busy && |(m_pend & ph_in_full)) m_stall++;
      if (e_dr) begin
        m_res++;
        if (mq.size() != 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (e_rd) begin
        mq.push_back(job_id);
        m_busy = 1; m_pend = 4'hF;
        m_n = job_normal; m_v = job_v0; m_o = job_origin; m_d = job_dir;
        m_jobs++;
      end else if (m_busy) begin
        m_pend = m_pend & ph_in_full;
        if (m_pend == 4'h0) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accepts;
    vec_t exp_v;
    reset = 1; job_empty = 1; job_id = '0;
    job_normal = '0; job_v0 = '0; job_origin = '0; job_dir = '0;
    ph_in_full = '0; ph_out = '0; ph_out_empty = 1; res_full = 0;
    tick(); tick();

    // Reset state: strobes gated even with a job waiting
    job_empty = 0;
    #1;
    check("rst_rd_en", job_rd_en, 0);
    check("rst_dir", ph_dir_1, 0);
    check("rst_err", err_underflow, 0);
    job_empty = 1;
    tick();
    reset = 0;
    tick();

    // 1: single job, no backpressure
    job_dir    = {32'h0, 32'h0, 32'h0001_0000};
    job_normal = {32'h0001_0000, 32'h0, 32'h0};
    job_v0     = {32'h5, 32'h6, 32'h7};
    job_origin = {32'h1, 32'h2, 32'h3};
    job_id     = 8'h2A;
    job_empty  = 0;
    #1 check("t1_rd", job_rd_en, 1);
    tick();
    job_empty = 1;
    #1;
    check("t1_wr_all", ph_in_wr_en, 4'hF);
    exp_v = {32'h0, 32'h0, 32'h0001_0000};
    check("t1_dir2", ph_dir_2, exp_v);
    tick();
    #1 check("t1_idle_wr", ph_in_wr_en, 4'h0);
    ph_out = {32'h0000_0003, 32'h0000_0002, 32'h0001_0000};
    ph_out_empty = 0;
    #1;
    check("t1_res_en", res_wr_en, 1);
    check("t1_res_id", res_id, 8'h2A);
    exp_v = {32'h0000_0003, 32'h0000_0002, 32'h0001_0000};
    check("t1_res_p", res_p, exp_v);
    tick();
    ph_out_empty = 1;

    // 2: lanes 0 and 2 full for three cycles
    job_id = 8'h33; job_dir = {32'h11, 32'h22, 32'h33}; job_empty = 0;
    tick();
    job_empty = 1; ph_in_full = 4'b0101;
    #1 check("t2_first", ph_in_wr_en, 4'b1010);
    tick();
    #1 check("t2_hold", ph_in_wr_en, 4'b0000);
    tick();
    tick();
    ph_in_full = 4'b0000;
    #1 check("t2_release", ph_in_wr_en, 4'b0101);
    tick();
    #1 check("t2_done", ph_in_wr_en, 4'b0000);
`ifdef P_HIT_DISPATCH_STATS_EN
    check("t2_stat_stall", stat_stall, 3);
    check("t2_stat_jobs", stat_jobs, 2);
`endif
    ph_out_empty = 0;
    #1 check("t2_res_id", res_id, 8'h33);
    tick();
    ph_out_empty = 1;

    // 3: 17 jobs with no results returning
    job_id = 8'h40; job_empty = 0; accepts = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (job_rd_en) begin
        accepts++;
        tick();
        job_id = job_id + 8'h01;
      end else begin
        tick();
      end
    end
    check("t3_accepts", accepts, 16);
    check("t3_held", job_rd_en, 0);
    ph_out_empty = 0;
    #1 check("t3_first_id", res_id, 8'h40);
    tick();
    ph_out_empty = 1;
    #1 check("t3_17th", job_rd_en, 1);
    tick();
    job_empty = 1;
    tick();

    // 4: downstream full blocks drain; ids leave in accept order afterwards
    res_full = 1; ph_out_empty = 0;
    #1;
    check("t4_rd_blocked", ph_out_rd_en, 0);
    check("t4_wr_blocked", res_wr_en, 0);
    tick(); tick();
    res_full = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("t4_order", res_id, 8'(8'h41 + k));
      check("t4_wr", res_wr_en, 1);
      tick();
    end
    ph_out_empty = 1;

    // 5: result with no tag queued
    ph_out_empty = 0;
    #1;
    check("t5_res_en", res_wr_en, 1);
    check("t5_res_id", res_id, 8'h00);
    tick();
    ph_out_empty = 1;
    #1 check("t5_err", err_underflow, 1);
    tick(); tick();
    check("t5_err_sticky", err_underflow, 1);

    // 6: reset in the middle of ISSUE with lanes 0,1 already written
    job_id = 8'h66; job_empty = 0;
    tick();
    ph_in_full = 4'b1100;
    #1 check("t6_first", ph_in_wr_en, 4'b0011);
    tick();
    #1 check("t6_stalled", ph_in_wr_en, 4'b0000);
    ph_out_empty = 0;
    reset = 1;
    #1;
    check("t6_rst_rd", job_rd_en, 0);
    check("t6_rst_wr", ph_in_wr_en, 4'b0000);
    check("t6_rst_out_rd", ph_out_rd_en, 0);
    check("t6_rst_res_wr", res_wr_en, 0);
    check("t6_rst_err", err_underflow, 0);
    tick();
    reset = 0; ph_in_full = 4'b0000; ph_out_empty = 1; job_empty = 1;
    #1 check("t6_idle", ph_in_wr_en, 4'b0000);
    job_empty = 0;
    #1 check("t6_accept", job_rd_en, 1);
    tick();
    job_empty = 1;
    tick(); tick();
    ph_out_empty = 0;
    #1 check("t6_res_id", res_id, 8'h66);
    tick();
    ph_out_empty = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
